fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
Parametrised streaming front/back-end for the pipelined FFT core (fftmain). Accepts complex samples over a valid/ready handshake and drives the core's clock-enable and sample input. Scans each output frame, starting from the core's sync flag, and reports the peak-magnitude bin per frame. Replaces the fixed test harness: generalised transform length and widths, adds frame accounting and sync-error detection, and shows a Gray-coded frame counter on the board LEDs.

Parameters:
IW, 12, input sample width per component (re/im, two's complement)
OW, 16, core output width per component
LGN, 10, log2 of transform length N
CW, 16, frame counter width
LEDW, 8, LED output width (LEDW <= CW)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  block accepts input sample
s_data  in  2*IW  {re, im} input sample
fft_ce  out  1  clock enable to core
fft_sample  out  2*IW  sample to core
fft_result  in  2*OW  {re, im} core output, meaningful only on cycles with fft_ce=1
fft_sync  in  1  core marks bin 0 of an output frame (qualified by fft_ce)
peak_valid  out  1  one-cycle pulse: peak result for the completed frame
peak_bin  out  LGN  index of the maximum-magnitude bin
peak_mag  out  OW+1  magnitude of that bin
frame_cnt  out  CW  completed output frames, wraps modulo 2^CW
sync_err  out  1  sticky: sync arrived mid-frame
led  out  LEDW  Gray code of frame_cnt[LEDW-1:0]

Behaviour:
- Reset is asynchronous, active-high, on clk. All outputs and state clear to 0; FSM enters WAIT_SYNC.
- s_ready is 0 while rst is asserted. It is 1 from the first cycle after rst deasserts (the core is fully streaming; no backpressure).
- fft_ce = s_valid & s_ready, combinational. fft_sample = s_data, combinational. No registers on the input path; zero latency.
- Output FSM (advances only on cycles with fft_ce=1):
  - WAIT_SYNC: on fft_sync=1, treat the current fft_result as bin 0. Load best_mag = mag(bin 0) and best_bin = 0, set bin_idx = 1, then go to SCAN. Otherwise stay.
  - SCAN: compute mag = |re| + |im|, unsigned, OW+1 bits. |-2^(OW-1)| = 2^(OW-1) with no saturation. If mag > best_mag (strictly greater), update best_mag and best_bin; ties keep the lower index. Increment bin_idx.
  - Last bin (bin_idx = N-1, update applied): on the next clk, peak_valid=1 for one cycle. peak_bin and peak_mag register the final best values and hold until the next report. frame_cnt increments. Return to WAIT_SYNC.
  - fft_sync=1 inside SCAN with bin_idx != 0: set sync_err=1 (sticky until rst). Discard the partial frame without reporting and restart from bin 0 with the current sample. frame_cnt is unchanged.
  - A frame ending exactly when the next sync arrives: the report issues and the new frame starts from bin 0 in the same ce cycle. No sync is lost.
- Cycles with fft_ce=0 freeze all scan state; fft_sync and fft_result are ignored.
- frame_cnt wraps from 2^CW-1 to 0 with no flag.
- led is registered: led <= g ^ (g >> 1), where g = frame_cnt[LEDW-1:0]. It lags frame_cnt by one cycle.
- Reset mid-frame: the partial scan is lost, no peak_valid is issued, and sync_err clears.

Optional Feature:
FFT_PEAK_HOLD_EN
- Defined: best_mag/best_bin are not reloaded at bin 0. They carry across frames, so peak_mag is the maximum since reset. peak_valid still pulses every frame. Ties keep the earlier-found bin.
- Undefined: per-frame peak as described above.

Decomposition:
- Package fft_ctrl_pkg holds:
  - FSM state enum (WAIT_SYNC, SCAN)
  - function abs_sum(re, im) returning OW+1 bits
  - function gray(x)
  - localparam N = 1 << LGN
- One sub-module, fft_peak_scan: the magnitude compare, best-value registers and bin counter. The top-level keeps the handshake, FSM sequencing, frame counter and LED encode.

Test Plan:
All scenarios use LGN=3, IW=12, OW=16, with a behavioural core model that emits sync on bin 0.
- Reset: assert rst mid-stream at bin 4 → all outputs 0 and s_ready=0 at once. After release, no peak_valid until a full frame follows the next sync.
- Single frame: bins re={1,2,3,-40,5,6,7,8}, im=0 → peak_valid pulses once, one cycle after bin 7, with peak_bin=3, peak_mag=40, frame_cnt=1, led=8'h01.
- Tie and extreme: bin 2 = {-32768,0}, bin 5 = {0,-32768} → peak_bin=2, peak_mag=32768.
- Stalls: s_valid toggles 1/0 randomly across a frame → same result as the ungapped frame. fft_sync pulses on ce=0 cycles are ignored.
- Early sync: sync at bin 5 → sync_err=1 and no report for the partial frame. The following full 8-bin frame reports correctly; frame_cnt counts only complete frames.
- Wrap with CW=4: 17 frames → frame_cnt=1 and led=gray(1)=1. With FFT_PEAK_HOLD_EN, a frame-1 peak of 100 followed by a frame-2 peak of 50 → peak_mag stays 100.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT frame controller.
//   fsm_state_t : output-frame sequencer states
//   abs_sum     : |re| + |im| of two signed components, exact (no saturation)
//   gray        : binary-reflected Gray code
//   n_bins      : transform length for a given log2 size
// Helpers work on FN_W-bit operands; callers size-cast in and out so one
// definition serves every parameterisation up to FN_W bits per component.
package fft_ctrl_pkg;

  localparam int unsigned FN_W = 32;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    SCAN      = 1'b1
  } fsm_state_t;

  function automatic int unsigned n_bins(input int unsigned lgn);
    return 1 << lgn;
  endfunction

  // One extra result bit keeps |-2^(FN_W-1)| and the sum of two such values exact.
  function automatic logic [FN_W:0] abs_sum(input logic signed [FN_W-1:0] re,
                                            input logic signed [FN_W-1:0] im);
    logic [FN_W:0] ext_re;
    logic [FN_W:0] ext_im;
    logic [FN_W:0] abs_re;
    logic [FN_W:0] abs_im;
    ext_re = {re[FN_W-1], re};
    ext_im = {im[FN_W-1], im};
    abs_re = re[FN_W-1] ? -ext_re : ext_re;
    abs_im = im[FN_W-1] ? -ext_im : ext_im;
    return abs_re + abs_im;
  endfunction

  function automatic logic [FN_W-1:0] gray(input logic [FN_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/fft_peak_scan.sv
// Peak search over one FFT output frame.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : ce-qualified sync; current result is bin 0 of a new frame
//   step        : ce-qualified non-sync sample while scanning
//   result      : {re, im} core output
//   last        : the sample being presented now is bin N-1
//   nxt_mag/bin : best magnitude/index including the current sample
// Build option FFT_PEAK_HOLD_EN: best values are never reloaded at bin 0,
// so they track the maximum over every scanned sample since reset.
module fft_peak_scan
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned OW  = 16,
  parameter int unsigned LGN = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [2*OW-1:0]   result,
  output logic              last,
  output logic [OW:0]       nxt_mag,
  output logic [LGN-1:0]    nxt_bin
);

  localparam int unsigned N = n_bins(LGN);
  localparam logic [LGN-1:0] LAST_BIN = LGN'(N - 1);

  logic [OW:0]    best_mag;
  logic [LGN-1:0] best_bin;
  logic [LGN-1:0] bin_idx;
  logic [OW:0]    mag;
  logic           better;
`ifdef FFT_PEAK_HOLD_EN
  logic [LGN-1:0] cur_bin;
`endif

  always_comb begin
    mag = (OW+1)'(abs_sum(FN_W'($signed(result[2*OW-1:OW])),
                          FN_W'($signed(result[OW-1:0]))));
    better  = (mag > best_mag);
    nxt_mag = best_mag;
    nxt_bin = best_bin;
`ifdef FFT_PEAK_HOLD_EN
    cur_bin = start ? '0 : bin_idx;
    if ((start || step) && better) begin
      nxt_mag = mag;
      nxt_bin = cur_bin;
    end
`else
    if (start) begin
      nxt_mag = mag;
      nxt_bin = '0;
    end else if (step && better) begin
      nxt_mag = mag;
      nxt_bin = bin_idx;
    end
`endif
  end

  assign last = (bin_idx == LAST_BIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_mag <= '0;
      best_bin <= '0;
      bin_idx  <= '0;
    end else begin
      if (start || step) begin
        best_mag <= nxt_mag;
        best_bin <= nxt_bin;
      end
      if (start) begin
        bin_idx <= LGN'(1);
      end else if (step) begin
        bin_idx <= bin_idx + LGN'(1);
      end
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Streaming front/back-end for the pipelined FFT core.
//   clk, rst            : clock, asynchronous active-high reset
//   s_valid/s_ready     : input sample handshake (no backpressure once out of reset)
//   s_data              : {re, im} input sample
//   fft_ce, fft_sample  : core clock enable and sample, combinational from input
//   fft_result,fft_sync : core output and bin-0 marker, qualified by fft_ce
//   peak_valid          : one-cycle pulse after the last bin of a complete frame
//   peak_bin, peak_mag  : peak index/magnitude, held until the next report
//   frame_cnt           : completed frames, wraps modulo 2^CW
//   sync_err            : sticky, set when sync arrives mid-frame
//   led                 : Gray code of frame_cnt[LEDW-1:0], one cycle behind
// Build option FFT_PEAK_HOLD_EN: peak tracks the maximum since reset.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned IW   = 12,
  parameter int unsigned OW   = 16,
  parameter int unsigned LGN  = 10,
  parameter int unsigned CW   = 16,
  parameter int unsigned LEDW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2*IW-1:0]   s_data,
  output logic              fft_ce,
  output logic [2*IW-1:0]   fft_sample,
  input  logic [2*OW-1:0]   fft_result,
  input  logic              fft_sync,
  output logic              peak_valid,
  output logic [LGN-1:0]    peak_bin,
  output logic [OW:0]       peak_mag,
  output logic [CW-1:0]     frame_cnt,
  output logic              sync_err,
  output logic [LEDW-1:0]   led
);

  fsm_state_t     state;
  logic           start;
  logic           step;
  logic           last;
  logic [OW:0]    nxt_mag;
  logic [LGN-1:0] nxt_bin;

  assign fft_ce     = s_valid & s_ready;
  assign fft_sample = s_data;

  // A qualified sync always opens a new frame, whether idle, mid-frame
  // (error + restart) or on the cycle right after a frame completed.
  assign start = fft_ce & fft_sync;
  assign step  = fft_ce & ~fft_sync & (state == SCAN);

  fft_peak_scan #(
    .OW  (OW),
    .LGN (LGN)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .step    (step),
    .result  (fft_result),
    .last    (last),
    .nxt_mag (nxt_mag),
    .nxt_bin (nxt_bin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_SYNC;
      s_ready    <= 1'b0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      frame_cnt  <= '0;
      sync_err   <= 1'b0;
      led        <= '0;
    end else begin
      s_ready    <= 1'b1;
      peak_valid <= 1'b0;
      led        <= LEDW'(gray(FN_W'(frame_cnt[LEDW-1:0])));
      if (start) begin
        if (state == SCAN) begin
          sync_err <= 1'b1;
        end
        state <= SCAN;
      end else if (step && last) begin
        peak_valid <= 1'b1;
        peak_bin   <= nxt_bin;
        peak_mag   <= nxt_mag;
        frame_cnt  <= frame_cnt + CW'(1);
        state      <= WAIT_SYNC;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;

  localparam int IW   = 12;
  localparam int OW   = 16;
  localparam int LGN  = 3;
  localparam int CW   = 4;
  localparam int LEDW = 4;
  localparam int N    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [2*IW-1:0]   s_data;
  logic              fft_ce;
  logic [2*IW-1:0]   fft_sample;
  logic [2*OW-1:0]   fft_result;
  logic              fft_sync;
  logic              peak_valid;
  logic [LGN-1:0]    peak_bin;
  logic [OW:0]       peak_mag;
  logic [CW-1:0]     frame_cnt;
  logic              sync_err;
  logic [LEDW-1:0]   led;

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .IW   (IW),
    .OW   (OW),
    .LGN  (LGN),
    .CW   (CW),
    .LEDW (LEDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .fft_ce     (fft_ce),
    .fft_sample (fft_sample),
    .fft_result (fft_result),
    .fft_sync   (fft_sync),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .frame_cnt  (frame_cnt),
    .sync_err   (sync_err),
    .led        (led)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: frames collected as whole lists, peak found by a search.
  int fr_re[$];
  int fr_im[$];
  bit collecting;
  bit exp_err;
  bit exp_pv;
  int exp_cnt;
  int exp_bin;
  int exp_mag;
  int exp_led;
  bit ready_m;
  int frames_done;
`ifdef FFT_PEAK_HOLD_EN
  int hold_mag;
  int hold_bin;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int gray4(input int c);
    int g;
    g = c & 15;
    return g ^ (g >> 1);
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_reset();
    fr_re.delete();
    fr_im.delete();
    collecting = 0;
    exp_err = 0;
    exp_pv = 0;
    exp_cnt = 0;
    exp_bin = 0;
    exp_mag = 0;
    exp_led = 0;
    ready_m = 0;
    frames_done = 0;
`ifdef FFT_PEAK_HOLD_EN
    hold_mag = 0;
    hold_bin = 0;
`endif
  endtask

  task automatic model_accept(input bit sy, input int re, input int im);
    int best;
    int m;
    if (sy) begin
      if (collecting && fr_re.size() > 0) exp_err = 1;
      fr_re.delete();
      fr_im.delete();
      collecting = 1;
    end
    if (collecting) begin
`ifdef FFT_PEAK_HOLD_EN
      m = absi(re) + absi(im);
      if (m > hold_mag) begin
        hold_mag = m;
        hold_bin = fr_re.size();
      end
`endif
      fr_re.push_back(re);
      fr_im.push_back(im);
      if (fr_re.size() == N) begin
`ifdef FFT_PEAK_HOLD_EN
        exp_mag = hold_mag;
        exp_bin = hold_bin;
`else
        best = -1;
        for (int i = 0; i < N; i++) begin
          m = absi(fr_re[i]) + absi(fr_im[i]);
          if (m > best) begin
            best = m;
            exp_bin = i;
          end
        end
        exp_mag = best;
`endif
        exp_pv = 1;
        exp_cnt = (exp_cnt + 1) % 16;
        frames_done++;
        collecting = 0;
        fr_re.delete();
        fr_im.delete();
      end
    end
  endtask

  // One clock: drive at negedge, model the edge, check just after posedge.
  task automatic step(input bit v, input bit sy, input int re, input int im);
    logic [15:0] r16;
    logic [15:0] i16;
    bit ce_e;
    @(negedge clk);
    r16 = re[15:0];
    i16 = im[15:0];
    s_valid = v;
    fft_sync = sy;
    fft_result = {r16, i16};
    s_data = (2*IW)'($urandom);
    #1;
    ce_e = v & ready_m;
    chk("fft_ce", fft_ce, ce_e);
    chk("fft_sample", fft_sample, s_data);
    exp_pv = 0;
    exp_led = gray4(exp_cnt);
    if (ce_e) model_accept(sy, re, im);
    @(posedge clk);
    #1;
    ready_m = 1;
    chk("s_ready", s_ready, 1);
    chk("peak_valid", peak_valid, exp_pv);
    chk("peak_bin", peak_bin, exp_bin);
    chk("peak_mag", peak_mag, exp_mag);
    chk("frame_cnt", frame_cnt, exp_cnt);
    chk("sync_err", sync_err, exp_err);
    chk("led", led, exp_led);
  endtask

  task automatic send_frame(input int ra[N], input int ia[N], input int gap_pct);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < 4 && int'($urandom_range(0, 99)) < gap_pct; g++)
        step(0, bit'($urandom_range(0, 1)), rnd16(), rnd16());
      step(1, i == 0, ra[i], ia[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_peak_valid"}, peak_valid, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
    chk({tag, "_peak_mag"}, peak_mag, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  initial begin
    int ra[N];
    int ia[N];

    rst = 1;
    s_valid = 0;
    fft_sync = 0;
    fft_result = '0;
    s_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 0;
    @(posedge clk);
    #1;
    ready_m = 1;
    chk("s_ready_release", s_ready, 1);

    // Single frame: peak at bin 3, magnitude 40.
    ra = '{1, 2, 3, -40, 5, 6, 7, 8};
    ia = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(ra, ia, 0);
    chk("single_bin", peak_bin, 3);
    chk("single_mag", peak_mag, 40);
    step(0, 0, 0, 0);
    chk("single_led", led, 1);

    // Tie between two extreme values: lower index wins.
    ra = '{0, 0, -32768, 0, 0, 0, 0, 0};
    ia = '{0, 0, 0, 0, 0, -32768, 0, 0};
    send_frame(ra, ia, 0);
    chk("tie_bin", peak_bin, 2);
    chk("tie_mag", peak_mag, 32768);

    // Reset in the middle of a frame.
    for (int i = 0; i < 4; i++) step(1, i == 0, rnd16(), rnd16());
    @(negedge clk);
    rst = 1;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    ready_m = 1;
    chk("s_ready_rerelease", s_ready, 1);
    for (int i = 4; i < N; i++) step(1, 0, rnd16(), rnd16());

    // Same random frame ungapped then with stalls.
    for (int i = 0; i < N; i++) begin
      ra[i] = rnd16();
      ia[i] = rnd16();
    end
    send_frame(ra, ia, 0);
    send_frame(ra, ia, 50);

    // Early sync: partial frame of 5, then a full frame.
    for (int i = 0; i < 5; i++) step(1, i == 0, rnd16(), rnd16());
    for (int i = 0; i < N; i++) begin
      ra[i] = rnd16();
      ia[i] = rnd16();
    end
    send_frame(ra, ia, 0);
    chk("early_sync_err", sync_err, 1);

    // Large peak followed by a smaller one.
    ra = '{3, -7, 10, 20, 100, 0, -5, 1};
    ia = '{0, 2, -4, 6, 0, 0, 9, -1};
    send_frame(ra, ia, 0);
    ra = '{1, 50, 0, -3, 4, 7, 0, 2};
    ia = '{0, 0, 5, 0, -6, 0, 2, 0};
    send_frame(ra, ia, 20);

    // Random back-to-back frames until 17 complete frames since reset.
    for (int k = 0; k < 40 && frames_done < 17; k++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = rnd16();
        ia[i] = rnd16();
      end
      send_frame(ra, ia, 15);
    end
    step(0, 0, 0, 0);
    chk("wrap_frame_cnt", frame_cnt, 1);
    chk("wrap_led", led, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
